// File: rtl/dm_rd_resp.sv
// Data-memory responder: word-addressed 32-bit array with a fixed-latency
// read port (req/busy/valid) and a never-stalling store-word write port.
module dm_rd_resp #(
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_rd_req_i,
  input  logic [31:0] dm_rd_addr_i,
  input  logic        dm_wr_req_i,
  input  logic [31:0] dm_wr_addr_i,
  input  logic [31:0] dm_wr_data_i,
  output logic        dm_busy_o,
  output logic        dm_rd_valid_o,
  output logic [31:0] dm_rd_data_o,
  output logic        dm_rd_err_o,
  output logic        dm_wr_err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAT_M2 = 4'(RD_LAT - 2);

  logic [31:0]   mem [0:(1 << AW) - 1];

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] rd_idx_q;
  logic          rd_bad_q;

  logic [AW-1:0] rd_idx_in;
  logic          rd_bad_in;
  logic [AW-1:0] wr_idx;
  logic          wr_bad;
  logic          wr_ok;
  logic          enter_resp;
  logic [AW-1:0] cap_idx;
  logic          cap_bad;

  always_comb begin
    rd_idx_in  = dm_rd_addr_i[AW+1:2];
    rd_bad_in  = (dm_rd_addr_i[1:0] != '0) || (dm_rd_addr_i[31:AW+2] != '0);
    wr_idx     = dm_wr_addr_i[AW+1:2];
    wr_bad     = (dm_wr_addr_i[1:0] != '0) || (dm_wr_addr_i[31:AW+2] != '0);
    wr_ok      = dm_wr_req_i && !wr_bad;
    enter_resp = ((state == IDLE) && dm_rd_req_i && (RD_LAT == 1)) ||
                 ((state == WAIT) && (cnt == '0));
    // With RD_LAT=1 the capture happens straight out of IDLE, so the
    // incoming address is used before it has been latched.
    cap_idx    = (state == IDLE) ? rd_idx_in : rd_idx_q;
    cap_bad    = (state == IDLE) ? rd_bad_in : rd_bad_q;
  end

  assign dm_busy_o     = (state != IDLE);
  assign dm_rd_valid_o = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_idx_q     <= '0;
      rd_bad_q     <= 1'b0;
      dm_rd_data_o <= '0;
      dm_rd_err_o  <= 1'b0;
      dm_wr_err_o  <= 1'b0;
    end else begin
      dm_wr_err_o <= dm_wr_req_i && wr_bad;
      case (state)
        IDLE: begin
          if (dm_rd_req_i) begin
            rd_idx_q <= rd_idx_in;
            rd_bad_q <= rd_bad_in;
            if (RD_LAT == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M2;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Write-before-read: a same-edge write to the captured index wins.
      if (enter_resp) begin
        dm_rd_err_o <= cap_bad;
        if (cap_bad)
          dm_rd_data_o <= '0;
        else if (wr_ok && (wr_idx == cap_idx))
          dm_rd_data_o <= dm_wr_data_i;
        else
          dm_rd_data_o <= mem[cap_idx];
      end
    end
  end

  // Array is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_idx] <= dm_wr_data_i;
  end

endmodule

// File: tb/tb_dm_rd_resp.sv
// Self-checking bench for dm_rd_resp: RD_LAT=2 and RD_LAT=1 instances checked
// every cycle against a cycle-indexed transaction model plus directed literals.
module tb_dm_rd_resp;

  logic        clk;
  logic        rst;
  logic        rq   [2];
  logic [31:0] ra   [2];
  logic        wq   [2];
  logic [31:0] wa   [2];
  logic [31:0] wd   [2];
  logic        busy [2];
  logic        vld  [2];
  logic [31:0] rdat [2];
  logic        rerr [2];
  logic        werr [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  dm_rd_resp #(.AW(10), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .dm_rd_req_i(rq[0]), .dm_rd_addr_i(ra[0]),
    .dm_wr_req_i(wq[0]), .dm_wr_addr_i(wa[0]), .dm_wr_data_i(wd[0]),
    .dm_busy_o(busy[0]), .dm_rd_valid_o(vld[0]), .dm_rd_data_o(rdat[0]),
    .dm_rd_err_o(rerr[0]), .dm_wr_err_o(werr[0])
  );

  dm_rd_resp #(.AW(10), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .dm_rd_req_i(rq[1]), .dm_rd_addr_i(ra[1]),
    .dm_wr_req_i(wq[1]), .dm_wr_addr_i(wa[1]), .dm_wr_data_i(wd[1]),
    .dm_busy_o(busy[1]), .dm_rd_valid_o(vld[1]), .dm_rd_data_o(rdat[1]),
    .dm_rd_err_o(rerr[1]), .dm_wr_err_o(werr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Transaction-level model: memory image, and for each instance the cycle a
  // read was accepted, the cycle it responds, and the first cycle a new read is taken.
  int          cyc = 0;
  int          lat_of [2] = '{2, 1};
  logic [31:0] mmem [2][1024];
  int          acc_at [2];
  int          resp_at [2];
  int          ready_at [2];
  int          pend_idx [2];
  logic        pend_bad [2];
  logic        exp_busy [2];
  logic        exp_vld  [2];
  logic [31:0] exp_data [2];
  logic        exp_err  [2];
  logic        exp_werr [2];

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h1000);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        acc_at[k] = -100; resp_at[k] = -100; ready_at[k] = 0;
        exp_busy[k] = 0; exp_vld[k] = 0; exp_data[k] = 0; exp_err[k] = 0; exp_werr[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_werr[k] = wq[k] && bad_addr(wa[k]);
        if (wq[k] && !bad_addr(wa[k])) mmem[k][wa[k] / 4] = wd[k];
        if (rq[k] && cyc >= ready_at[k]) begin
          acc_at[k]   = cyc;
          resp_at[k]  = cyc + lat_of[k];
          ready_at[k] = cyc + lat_of[k] + 1;
          pend_bad[k] = bad_addr(ra[k]);
          pend_idx[k] = int'(ra[k] / 4) % 1024;
        end
        exp_vld[k]  = (cyc + 1 == resp_at[k]);
        exp_busy[k] = (cyc + 1 > acc_at[k]) && (cyc + 1 <= resp_at[k]);
        if (exp_vld[k]) begin
          exp_err[k]  = pend_bad[k];
          exp_data[k] = pend_bad[k] ? 32'h0 : mmem[k][pend_idx[k]];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m_busy%0d", k), 32'(busy[k]), 32'(exp_busy[k]));
      chk($sformatf("m_vld%0d", k),  32'(vld[k]),  32'(exp_vld[k]));
      chk($sformatf("m_data%0d", k), rdat[k],      exp_data[k]);
      chk($sformatf("m_err%0d", k),  32'(rerr[k]), 32'(exp_err[k]));
      chk($sformatf("m_werr%0d", k), 32'(werr[k]), 32'(exp_werr[k]));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d);
    wq[k] = 1'b1; wa[k] = a; wd[k] = d;
    step;
    wq[k] = 1'b0;
  endtask

  // Issue a read from idle, wait (bounded) for valid, return data/err/latency.
  task automatic rd(input int k, input logic [31:0] a,
                    output logic [31:0] d, output logic e, output int lat);
    rq[k] = 1'b1; ra[k] = a;
    step;
    rq[k] = 1'b0;
    lat = 1;
    while (!vld[k] && lat < 20) begin
      step;
      lat++;
    end
    d = rdat[k];
    e = rerr[k];
    step;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rq[k] = 0; ra[k] = 0; wq[k] = 0; wa[k] = 0; wd[k] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_vld",  32'(vld[0]),  32'h0);
    chk("rst_data", rdat[0],      32'h0);

    // Basic read, RD_LAT=2
    wr(0, 32'h10, 32'hDEADBEEF);
    wr(0, 32'h0,  32'hA5A5A5A5);
    rq[0] = 1'b1; ra[0] = 32'h10;
    step;
    rq[0] = 1'b0;
    chk("t1_busy_n1", 32'(busy[0]), 32'h1);
    chk("t1_vld_n1",  32'(vld[0]),  32'h0);
    step;
    chk("t1_busy_n2", 32'(busy[0]), 32'h1);
    chk("t1_vld_n2",  32'(vld[0]),  32'h1);
    chk("t1_data",    rdat[0],      32'hDEADBEEF);
    chk("t1_err",     32'(rerr[0]), 32'h0);
    step;
    chk("t1_busy_n3", 32'(busy[0]), 32'h0);
    chk("t1_vld_n3",  32'(vld[0]),  32'h0);
    chk("t1_hold",    rdat[0],      32'hDEADBEEF);

    // Write during WAIT to the pending index is forwarded
    rq[0] = 1'b1; ra[0] = 32'h20;
    step;
    rq[0] = 1'b0;
    wq[0] = 1'b1; wa[0] = 32'h20; wd[0] = 32'h12345678;
    step;
    wq[0] = 1'b0;
    chk("t2_vld",  32'(vld[0]), 32'h1);
    chk("t2_data", rdat[0],     32'h12345678);
    step;

    // Request held high: responses at offsets 2, 5, 8
    for (int i = 0; i < 9; i++) begin
      rq[0] = 1'b1; ra[0] = 32'h10;
      chk($sformatf("t3_vld_%0d", i), 32'(vld[0]), 32'((i == 2) || (i == 5) || (i == 8)));
      step;
    end
    rq[0] = 1'b0;
    step;

    // Bad addresses
    rd(0, 32'h13, d, e, lat);
    chk("t4_mis_err", 32'(e), 32'h1);
    chk("t4_mis_data", d, 32'h0);
    chk("t4_mis_lat", lat, 2);
    rd(0, 32'h1000, d, e, lat);
    chk("t4_oor_err", 32'(e), 32'h1);
    chk("t4_oor_data", d, 32'h0);
    wq[0] = 1'b1; wa[0] = 32'h1000; wd[0] = 32'hFFFFFFFF;
    step;
    wq[0] = 1'b0;
    chk("t4_werr_pulse", 32'(werr[0]), 32'h1);
    step;
    chk("t4_werr_clr", 32'(werr[0]), 32'h0);
    rd(0, 32'h0, d, e, lat);
    chk("t4_word0", d, 32'hA5A5A5A5);
    chk("t4_word0_err", 32'(e), 32'h0);

    // Reset mid-read, with a write on the reset edge
    rq[0] = 1'b1; ra[0] = 32'h10;
    step;
    rq[0] = 1'b0;
    wq[0] = 1'b1; wa[0] = 32'h10; wd[0] = 32'h55555555;
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy[0]), 32'h0);
    chk("t5_vld",  32'(vld[0]),  32'h0);
    chk("t5_data", rdat[0],      32'h0);
    chk("t5_err",  32'(rerr[0]), 32'h0);
    @(posedge clk);
    #1;
    wq[0] = 1'b0;
    rst = 1'b0;
    repeat (3) step;
    rd(0, 32'h10, d, e, lat);
    chk("t5_after_data", d, 32'hDEADBEEF);
    chk("t5_after_lat", lat, 2);

    // RD_LAT=1: same-cycle write and read in IDLE
    wr(1, 32'h40, 32'h11111111);
    rq[1] = 1'b1; ra[1] = 32'h40;
    wq[1] = 1'b1; wa[1] = 32'h40; wd[1] = 32'h22222222;
    step;
    rq[1] = 1'b0; wq[1] = 1'b0;
    chk("t6_vld",  32'(vld[1]),  32'h1);
    chk("t6_busy", 32'(busy[1]), 32'h1);
    chk("t6_data", rdat[1],      32'h22222222);
    step;
    rd(1, 32'h40, d, e, lat);
    chk("t6_rd_data", d, 32'h22222222);
    chk("t6_rd_lat", lat, 1);

    repeat (2) step;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dm_rd_resp.md
Name: dm_rd_resp

Overview:
- Data-memory responder: the far end of the decode stage's data-memory read request (dm_rd_req / dm_rd_addr). It also services the store-word write port driven from the execute side.
- Holds a word-addressed 32-bit array and returns read data after a fixed programmable latency, using a req/busy/valid handshake.
- Sits between the id/ex pipeline and the writeback mux, which consumes dm_rd_data_o for lw.

Parameters:
- AW, 10, word-address width; array depth is 2^AW words of 32 bits.
- RD_LAT, 2, cycles from the request cycle to the response cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dm_rd_req_i  in  1  read request; sampled only when dm_busy_o=0.
- dm_rd_addr_i  in  32  byte address of the read.
- dm_wr_req_i  in  1  write request; accepted in any cycle.
- dm_wr_addr_i  in  32  byte address of the write.
- dm_wr_data_i  in  32  write data.
- dm_busy_o  out  1  high while a read is outstanding (state != IDLE).
- dm_rd_valid_o  out  1  one-cycle pulse; response data is valid.
- dm_rd_data_o  out  32  read data; held until the next response or reset.
- dm_rd_err_o  out  1  qualifies dm_rd_valid_o; the read address was misaligned or out of range.
- dm_wr_err_o  out  1  one-cycle pulse; a write was dropped because its address was misaligned or out of range.

Behaviour:
- Address rules:
  - Index = addr[AW+1:2].
  - Misaligned if addr[1:0] != 0.
  - Out of range if addr[31:AW+2] != 0.
  - Bad read: completes with normal timing; dm_rd_err_o=1, dm_rd_data_o=0.
  - Bad write: array unchanged; dm_wr_err_o pulses in the next cycle.
- Reset (asynchronous): state=IDLE, latency counter=0, all outputs 0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if dm_rd_req_i=1, latch address and error flag. Go to RESP when RD_LAT=1; otherwise go to WAIT with cnt=RD_LAT-2.
  - WAIT: if cnt=0, go to RESP; else cnt-=1.
  - On the edge entering RESP: capture array[index] into dm_rd_data_o (0 on error) and set dm_rd_err_o.
  - RESP: dm_rd_valid_o=1 for exactly this one cycle; next state is IDLE.
- Latency: request in cycle n gives dm_rd_valid_o in cycle n+RD_LAT.
- Busy and throughput:
  - dm_busy_o=1 from cycle n+1 through cycle n+RD_LAT, inclusive.
  - The next request is accepted at cycle n+RD_LAT+1 at the earliest.
  - dm_rd_req_i is ignored while busy; the requester holds the request until busy falls.
- Writes:
  - Performed on the edge ending the cycle they are presented in, in any state.
  - A write never stalls and never changes dm_busy_o.
- Forwarding: if a valid write hits the same index on the same edge that data is captured into RESP, dm_rd_data_o takes dm_wr_data_i (write-before-read). Writes during WAIT to the pending index are therefore visible in the response.
- Simultaneous read and write requests in IDLE are both accepted.
- Reset mid-read: the outstanding read is abandoned, no valid pulse is produced, and a write on that edge is not performed.
- dm_rd_err_o and dm_rd_data_o change only on the edge entering RESP, or on reset.
- dm_wr_err_o is a registered pulse.

Test Plan:
- Reset then write 0xDEADBEEF to 0x10; read 0x10 (RD_LAT=2) in cycle 5 -> busy=1 in cycles 6-7, valid=1 only in cycle 7, data=0xDEADBEEF, err=0.
- Read 0x20 in cycle n; write 0x12345678 to 0x20 in cycle n+1 (WAIT) -> response data=0x12345678.
- Read request held high continuously with RD_LAT=2 -> responses in cycles n+2, n+5, n+8; no request is accepted while busy.
- Read 0x13 and read 0x00001000 (AW=10) -> valid with err=1, data=0. Write 0x00001000 -> dm_wr_err_o pulses, and a later read of 0x0 is unchanged.
- Assert rst in cycle n+1 of a read -> no valid pulse, outputs 0 asynchronously; a new read after release completes normally.
- RD_LAT=1 build: read in cycle n -> valid in cycle n+1. Same-cycle write and read to 0x40 in IDLE -> response returns the new data.
